// File: rtl/cache_pkg.sv
// Shared cache/memory constants and enums used by the arbiter and both caches.
//   WORDS_PER_BLOCK_DEF : default words per cache block
//   WORD_IDX_W          : width of a word index within a block
//   MEM_LATENCY         : cycles from a read issue to mem_data_valid
//   BLOCK_OFFSET_MASK   : byte-offset bits inside a 16-byte block
package cache_pkg;

  localparam int unsigned WORDS_PER_BLOCK_DEF = 8;
  localparam int unsigned WORD_IDX_W          = 3;
  localparam int unsigned MEM_LATENCY         = 4;
  localparam logic [15:0] BLOCK_OFFSET_MASK   = 16'h000F;

  typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

endpackage

// File: rtl/cache_mem_arbiter_fill_sequencer.sv
// Block-fill sequencer: issues one read per cycle across a block and counts
// returning words.
//   clk, rst_n     : clock, async active-low reset
//   start          : high for the whole fill; low clears both counters
//   base           : block-aligned byte address of the block being filled
//   mem_data_valid : memory read data valid
//   mem_en         : read issue strobe
//   mem_addr       : read byte address (base + 2*issue_cnt)
//   word           : index of the word currently returning
//   we             : returning word is part of this fill
//   done           : the returning word is the last one of the block
module fill_sequencer #(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned WORDS_PER_BLOCK = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [ADDR_W-1:0]                  base,
  input  logic                               mem_data_valid,
  output logic                               mem_en,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] word,
  output logic                               we,
  output logic                               done
);

  localparam int unsigned IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] rx_cnt;

  // Outputs decode straight from the counters so the first read goes out in
  // the first fill cycle and each word is forwarded in its valid cycle.
  always_comb begin
    mem_en   = start && (issue_cnt < CNT_W'(WORDS_PER_BLOCK));
    mem_addr = base + (ADDR_W'(issue_cnt) << 1);
    we       = start && mem_data_valid && (rx_cnt < CNT_W'(WORDS_PER_BLOCK));
    done     = we && (rx_cnt == CNT_W'(WORDS_PER_BLOCK - 1));
    word     = rx_cnt[IDX_W-1:0];
  end

  // Issue and receive counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      rx_cnt    <= '0;
    end else if (!start || done) begin
      issue_cnt <= '0;
      rx_cnt    <= '0;
    end else begin
      if (mem_en) issue_cnt <= issue_cnt + CNT_W'(1);
      if (we)     rx_cnt    <= rx_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares main memory between the icache and dcache: 8-word block fills on
// misses (round-robin when both miss) and single-word write-through stores.
//   clk, rst_n                      : clock, async active-low reset
//   i_miss, i_miss_addr             : icache fill request (level)
//   i_fill_we/word/data/done        : icache fill return, done on last word
//   d_miss, d_miss_addr             : dcache fill request (level)
//   d_fill_we/word/data/done        : dcache fill return, done on last word
//   d_wr_req/addr/data, d_wr_ack    : dcache store request and issue pulse
//   mem_en/wr/addr/wdata            : memory command
//   mem_rdata, mem_data_valid       : memory read return
//   busy                            : arbiter not idle
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_miss,
  input  logic [ADDR_W-1:0]                  i_miss_addr,
  output logic                               i_fill_we,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] i_fill_word,
  output logic [DATA_W-1:0]                  i_fill_data,
  output logic                               i_fill_done,
  input  logic                               d_miss,
  input  logic [ADDR_W-1:0]                  d_miss_addr,
  output logic                               d_fill_we,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] d_fill_word,
  output logic [DATA_W-1:0]                  d_fill_data,
  output logic                               d_fill_done,
  input  logic                               d_wr_req,
  input  logic [ADDR_W-1:0]                  d_wr_addr,
  input  logic [DATA_W-1:0]                  d_wr_data,
  output logic                               d_wr_ack,
  output logic                               mem_en,
  output logic                               mem_wr,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic [DATA_W-1:0]                  mem_wdata,
  input  logic [DATA_W-1:0]                  mem_rdata,
  input  logic                               mem_data_valid,
  output logic                               busy
);

  localparam int unsigned IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(WORDS_PER_BLOCK * 2 - 1);

  state_t             state_q, state_d;
  owner_t             owner_q, owner_d;
  owner_t             last_miss_q, last_miss_d;
  owner_t             grant_c;
  logic [ADDR_W-1:0]  base_q, base_d;

  logic               seq_mem_en;
  logic [ADDR_W-1:0]  seq_addr;
  logic [IDX_W-1:0]   seq_word;
  logic               seq_we;
  logic               seq_done;

  fill_sequencer #(
    .ADDR_W          (ADDR_W),
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
  ) u_fill_sequencer (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (state_q == FILL),
    .base           (base_q),
    .mem_data_valid (mem_data_valid),
    .mem_en         (seq_mem_en),
    .mem_addr       (seq_addr),
    .word           (seq_word),
    .we             (seq_we),
    .done           (seq_done)
  );

  // State, owner, round-robin flag and block base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      last_miss_q <= OWN_I;
      base_q      <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_miss_q <= last_miss_d;
      base_q      <= base_d;
    end
  end

  // Next state, grant and output steering.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_miss_d = last_miss_q;
    base_d      = base_q;
    grant_c     = OWN_I;
    i_fill_we   = 1'b0;
    i_fill_word = '0;
    i_fill_data = '0;
    i_fill_done = 1'b0;
    d_fill_we   = 1'b0;
    d_fill_word = '0;
    d_fill_data = '0;
    d_fill_done = 1'b0;
    d_wr_ack    = 1'b0;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    busy        = (state_q != IDLE);

    // Both missing: serve the side that was not served last.
    if (i_miss && d_miss) grant_c = (last_miss_q == OWN_I) ? OWN_D : OWN_I;
    else if (d_miss)      grant_c = OWN_D;

    case (state_q)
      IDLE: begin
        if (d_wr_req) begin
          state_d = WRITE;
        end else if (i_miss || d_miss) begin
          owner_d     = grant_c;
          last_miss_d = grant_c;
          base_d      = ((grant_c == OWN_D) ? d_miss_addr : i_miss_addr) & ~OFFSET_MASK;
          state_d     = FILL;
        end
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        d_wr_ack  = 1'b1;
        state_d   = IDLE;
      end
      FILL: begin
        mem_en   = seq_mem_en;
        mem_addr = seq_addr;
        if (seq_we) begin
          if (owner_q == OWN_D) begin
            d_fill_we   = 1'b1;
            d_fill_word = seq_word;
            d_fill_data = mem_rdata;
            d_fill_done = seq_done;
          end else begin
            i_fill_we   = 1'b1;
            i_fill_word = seq_word;
            i_fill_data = mem_rdata;
            i_fill_done = seq_done;
          end
        end
        if (seq_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
